// File: rtl/alu_pkg.sv
// Shared opcodes, controller state encoding and result flag bundle
// for the ALU issue controller.
package alu_pkg;

  localparam logic [7:0] OP_ADD      = 8'h00;
  localparam logic [7:0] OP_SUB      = 8'h01;
  localparam logic [7:0] OP_MUL      = 8'h02;
  localparam logic [7:0] OP_LDB      = 8'h10;
  localparam logic [7:0] OP_LDW      = 8'h11;
  localparam logic [7:0] OP_STB      = 8'h12;
  localparam logic [7:0] OP_STW      = 8'h13;
  localparam logic [7:0] OP_MOV      = 8'h14;
  localparam logic [7:0] OP_BEQ      = 8'h30;
  localparam logic [7:0] OP_JUMP     = 8'h31;
  localparam logic [7:0] OP_TLBWRITE = 8'h32;
  localparam logic [7:0] OP_IRET     = 8'h33;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic mem;
    logic br;
    logic sys;
    logic ill;
  } rsp_flags_t;

  function automatic logic is_mem_op(input logic [7:0] op);
    return op[7:2] == 6'b000100;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle multiply sequencer: latches operands on start and
// raises done on the cycle the countdown reaches zero.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] prod_o
);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // done marks the edge on which the counter steps from 1 to 0
  assign done_o = busy_q && (cnt_q == CNT_W'(1));
  assign prod_o = a_q * b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(LAT - 1);
      a_q    <= a_i;
      b_q    <= b_i;
    end else if (busy_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: one instruction in flight, registered result.
// Perf counters are built only with ALU_ISSUE_PERF_EN defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int MUL_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_opcode,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic [REG_W-1:0]  req_dst,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [REG_W-1:0]  rsp_dst,
  output logic              rsp_is_mem,
  output logic              rsp_br_taken,
  output logic              rsp_is_sys,
  output logic              rsp_illegal,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
);

  state_e            state_q;
  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic [REG_W-1:0]  dst_q;
  rsp_flags_t        flags_q;

  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;
  logic [DATA_W-1:0] result_d;
  rsp_flags_t        flags_d;

  assign req_ready = !flush &&
    (state_q == ST_IDLE ||
     (state_q == ST_RESP && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign mul_start = accept && req_opcode == OP_MUL;

  alu_mul_seq #(
    .DATA_W (DATA_W),
    .LAT    (MUL_LATENCY)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .start_i (mul_start),
    .a_i     (req_src1),
    .b_i     (req_src2),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    unique case (1'b1)
      req_opcode == OP_ADD:
        result_d = req_src1 + req_src2;
      req_opcode == OP_SUB:
        result_d = req_src1 - req_src2;
      req_opcode == OP_MUL: ;
      is_mem_op(req_opcode): begin
        result_d    = req_src1 + req_src2;
        flags_d.mem = 1'b1;
      end
      req_opcode == OP_MOV:
        result_d = req_src2;
      req_opcode == OP_BEQ: begin
        result_d   = DATA_W'(req_src1 == req_src2);
        flags_d.br = req_src1 == req_src2;
      end
      req_opcode == OP_JUMP: begin
        result_d   = req_src1 + req_src2;
        flags_d.br = 1'b1;
      end
      req_opcode == OP_TLBWRITE,
      req_opcode == OP_IRET:
        flags_d.sys = 1'b1;
      default:
        flags_d.ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      dst_q    <= '0;
      flags_q  <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
    end else if (accept) begin
      dst_q <= req_dst;
      if (req_opcode == OP_MUL) begin
        state_q  <= ST_MUL;
        valid_q  <= 1'b0;
        result_q <= '0;
        flags_q  <= '0;
      end else begin
        state_q  <= ST_RESP;
        valid_q  <= 1'b1;
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end else begin
      case (state_q)
        ST_MUL: if (mul_done) begin
          state_q  <= ST_RESP;
          valid_q  <= 1'b1;
          result_q <= mul_prod;
        end
        ST_RESP: if (rsp_ready) begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid    = valid_q;
  assign rsp_result   = result_q;
  assign rsp_dst      = dst_q;
  assign rsp_is_mem   = flags_q.mem;
  assign rsp_br_taken = flags_q.br;
  assign rsp_is_sys   = flags_q.sys;
  assign rsp_illegal  = flags_q.ill;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issued_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (accept) issued_q <= issued_q + 32'd1;
      if (req_valid && !req_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl against a behavioural
// opcode model and the documented handshake timing.
module tb_alu_issue_ctrl;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_opcode = '0;
  logic [DW-1:0] req_src1 = '0;
  logic [DW-1:0] req_src2 = '0;
  logic [RW-1:0] req_dst = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic [RW-1:0] rsp_dst;
  logic          rsp_is_mem, rsp_br_taken, rsp_is_sys, rsp_illegal;
  logic [31:0]   perf_issued, perf_stall;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DW), .REG_W(RW), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_src1(req_src1),
    .req_src2(req_src2), .req_dst(req_dst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_dst(rsp_dst),
    .rsp_is_mem(rsp_is_mem), .rsp_br_taken(rsp_br_taken),
    .rsp_is_sys(rsp_is_sys), .rsp_illegal(rsp_illegal),
    .perf_issued(perf_issued), .perf_stall(perf_stall)
  );

  // returns {result, dst, mem, br, sys, ill}
  function automatic logic [DW+RW+3:0] model(
    input logic [7:0] op, input logic [DW-1:0] a, b,
    input logic [RW-1:0] d);
    logic [DW-1:0] r;
    logic [3:0] f;
    r = '0;
    f = '0;
    if (op == 8'h00) r = a + b;
    else if (op == 8'h01) r = a - b;
    else if (op == 8'h02) r = a * b;
    else if (op >= 8'h10 && op <= 8'h13) begin r = a + b; f[3] = 1'b1; end
    else if (op == 8'h14) r = b;
    else if (op == 8'h30) begin r = (a == b) ? 1 : 0; f[2] = (a == b); end
    else if (op == 8'h31) begin r = a + b; f[2] = 1'b1; end
    else if (op == 8'h32 || op == 8'h33) f[1] = 1'b1;
    else f[0] = 1'b1;
    return {r, d, f};
  endfunction

  function automatic logic [DW+RW+3:0] obs();
    return {rsp_result, rsp_dst, rsp_is_mem, rsp_br_taken,
            rsp_is_sys, rsp_illegal};
  endfunction

  // drive one request, wait for acceptance and then for rsp_valid;
  // returns the number of cycles from accept to rsp_valid
  task automatic issue_wait(input logic [7:0] op,
    input logic [DW-1:0] a, b, input logic [RW-1:0] d,
    output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = op;
    req_src1 = a; req_src2 = b; req_dst = d;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rsp_valid, obs()} !== '0) begin
      bad++;
      $display("FAIL reset_rsp got %h want 0", {rsp_valid, obs()});
    end
    total++;
    if ({perf_issued, perf_stall} !== 64'd0) begin
      bad++;
      $display("FAIL reset_perf got %h want 0", {perf_issued, perf_stall});
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_single();
    int lat;
    issue_wait(8'h00, 32'd5, 32'd7, 5'd3, lat);
    total++;
    if (lat != 1 || obs() !== model(8'h00, 32'd5, 32'd7, 5'd3)) begin
      bad++;
      $display("FAIL add lat=%0d got %h want %h", lat, obs(),
               model(8'h00, 32'd5, 32'd7, 5'd3));
    end
    issue_wait(8'h01, 32'd3, 32'd5, 5'd4, lat);
    total++;
    if (lat != 1 || rsp_result !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL sub lat=%0d got %h want fffffffe", lat, rsp_result);
    end
  endtask

  task automatic test_mul();
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 8'h02;
    req_src1 = 32'd6; req_src2 = 32'd7; req_dst = 5'd9;
    @(posedge clk);
    for (int c = 1; c < L; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL mul_busy c=%0d got rdy=%b vld=%b want 0 0",
                 c, req_ready, rsp_valid);
      end
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || obs() !== model(8'h02, 32'd6, 32'd7, 5'd9)) begin
      bad++;
      $display("FAIL mul_6x7 vld=%b got %h want %h", rsp_valid, obs(),
               model(8'h02, 32'd6, 32'd7, 5'd9));
    end
    issue_wait(8'h02, 32'h10000, 32'h10000, 5'd1, lat);
    total++;
    if (lat != L || rsp_result !== 32'd0) begin
      bad++;
      $display("FAIL mul_wrap lat=%0d got %h want lat %0d res 0",
               lat, rsp_result, L);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]    ops[3] = '{8'h11, 8'h30, 8'h30};
    logic [DW-1:0] as[3]  = '{32'h100, 32'd9, 32'd9};
    logic [DW-1:0] bs[3]  = '{32'd4, 32'd9, 32'd8};
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        total++;
        if (rsp_valid !== 1'b1 ||
            obs() !== model(ops[i-1], as[i-1], bs[i-1], RW'(i + 10))) begin
          bad++;
          $display("FAIL b2b_%0d vld=%b got %h want %h", i - 1, rsp_valid,
                   obs(), model(ops[i-1], as[i-1], bs[i-1], RW'(i + 10)));
        end
      end
      if (i < 3) begin
        req_valid = 1'b1; req_opcode = ops[i];
        req_src1 = as[i]; req_src2 = bs[i]; req_dst = RW'(i + 11);
        #1;
        total++;
        if (req_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready_%0d got %b want 1", i, req_ready);
        end
      end else req_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_opcode = 8'h00;
    req_src1 = 32'd1; req_src2 = 32'd1; req_dst = 5'd2;
    @(negedge clk);
    req_src1 = 32'd3; req_src2 = 32'd4; req_dst = 5'd7;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd2 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d vld=%b res=%h rdy=%b want 1 2 0",
                 k, rsp_valid, rsp_result, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_ready got %b want 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || obs() !== model(8'h00, 32'd3, 32'd4, 5'd7)) begin
      bad++;
      $display("FAIL release_rsp got %h want %h", obs(),
               model(8'h00, 32'd3, 32'd4, 5'd7));
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 8'h02;
    req_src1 = 32'd5; req_src2 = 32'd5; req_dst = 5'd1;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_idle vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
    seen = 0;
    repeat (L + 2) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_quiet got %0d valid cycles want 0", seen);
    end
    issue_wait(8'h00, 32'd2, 32'd2, 5'd6, lat);
    total++;
    if (lat != 1 || rsp_result !== 32'd4) begin
      bad++;
      $display("FAIL flush_after lat=%0d got %h want 4", lat, rsp_result);
    end
  endtask

  task automatic test_illegal();
    int lat;
    issue_wait(8'hFF, 32'd8, 32'd8, 5'd5, lat);
    total++;
    if (lat != 1 || obs() !== model(8'hFF, 32'd8, 32'd8, 5'd5)) begin
      bad++;
      $display("FAIL illegal lat=%0d got %h want %h", lat, obs(),
               model(8'hFF, 32'd8, 32'd8, 5'd5));
    end
  endtask

  task automatic test_random();
    logic [7:0] tbl[13] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12,
                            8'h13, 8'h14, 8'h30, 8'h31, 8'h32, 8'h33, 8'h00};
    logic [7:0] op;
    logic [DW-1:0] a, b;
    logic [RW-1:0] d;
    int lat;
    int want_lat;
    for (int i = 0; i < 40; i++) begin
      op = (i % 7 == 6) ? 8'($urandom) : tbl[$urandom_range(0, 12)];
      a = $urandom;
      b = (op == 8'h30 && $urandom_range(0, 1) == 1) ? a : $urandom;
      d = RW'($urandom);
      want_lat = (op == 8'h02) ? L : 1;
      issue_wait(op, a, b, d, lat);
      total++;
      if (lat != want_lat || obs() !== model(op, a, b, d)) begin
        bad++;
        $display("FAIL rand_%0d op=%h lat=%0d/%0d got %h want %h",
                 i, op, lat, want_lat, obs(), model(op, a, b, d));
      end
    end
  endtask

  task automatic test_rst_mid_mul();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 8'h02;
    req_src1 = 32'd3; req_src2 = 32'd3; req_dst = 5'd8;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, obs(), perf_issued, perf_stall} !== '0) begin
      bad++;
      $display("FAIL rst_mid got %h want 0",
               {rsp_valid, obs(), perf_issued, perf_stall});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (L + 2) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_quiet got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_perf();
    int lat;
    logic [31:0] want_iss, want_stl;
`ifdef ALU_ISSUE_PERF_EN
    want_iss = 32'd2;
    want_stl = 32'(L - 1);
`else
    want_iss = 32'd0;
    want_stl = 32'd0;
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue_wait(8'h02, 32'd2, 32'd3, 5'd1, lat);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_opcode = 8'h02;
    req_src1 = 32'd2; req_src2 = 32'd3; req_dst = 5'd1;
    @(negedge clk);
    req_opcode = 8'h00;
    for (int c = 0; c < 20 && !req_ready; c++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (perf_issued !== want_iss || perf_stall !== want_stl) begin
      bad++;
      $display("FAIL perf got iss=%0d stl=%0d want %0d %0d",
               perf_issued, perf_stall, want_iss, want_stl);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    test_rst_mid_mul();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
